// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared op/state encodings and decode helpers for the mul/div sequencer
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // Quotient reported for any divide by zero; sliced to the operand width by users.
   localparam logic [63:0] DIV0_QUOT = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   typedef enum logic {
      M_MUL = 1'b0,
      M_DIV = 1'b1
   } step_mode_t;

   function automatic logic op_is_muldiv(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op[2:1] == 2'b01);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op[2] == 1'b0) && (op[0] == 1'b0);
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// rtl/hilo_muldiv_ctrl_if.sv - EX-stage issue/result bundle between the pipeline and the HI/LO sequencer
interface hilo_muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_ctrl_step.sv
// rtl/hilo_muldiv_ctrl_step.sv - one combinational radix-2 shift-add multiply or restoring divide iteration
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  step_mode_t         mode,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   part;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      part     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff     = {1'b0, part} - {2'b00, operand};
      q_bit    = 1'b0;
      acc_next = acc;
      if (mode == M_MUL) begin
         // acc = {partial product, remaining multiplier bits}; shift right with carry-in
         if (acc[0])
            acc_next = {sum, acc[WIDTH-1:1]};
         else
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end else begin
         // acc = {remainder, dividend bits}; the quotient bit is merged in by the caller
         q_bit    = ~diff[WIDTH+1];
         acc_next = {(q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Build option MULDIV_FAST_MUL_EN: multiplies bypass the iterative loop via a single-cycle product.
module hilo_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input logic               clk,
   input logic               rst,
   hilo_muldiv_ctrl_if.slave bus
);
   state_t             state, state_n;
   logic               launch, mt_wr, commit;

   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   opnd;
   logic [CNT_W-1:0]   cnt;
   step_mode_t         mode_r;
   logic               neg_q, neg_r, div0;
   logic               q_bit;

   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               done_r;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [WIDTH:0] fa, fb;
   logic [2*WIDTH-1:0]    fprod;

   always_comb begin
      fa    = $signed({op_is_signed(bus.op) & bus.src_a[WIDTH-1], bus.src_a});
      fb    = $signed({op_is_signed(bus.op) & bus.src_b[WIDTH-1], bus.src_b});
      fprod = (2*WIDTH)'(fa * fb);
   end
`endif

   assign bus.busy = (state != S_IDLE);
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   always_comb begin
      a_neg = op_is_signed(bus.op) && bus.src_a[WIDTH-1];
      b_neg = op_is_signed(bus.op) && bus.src_b[WIDTH-1];
      a_mag = a_neg ? -bus.src_a : bus.src_a;
      b_mag = b_neg ? -bus.src_b : bus.src_b;
   end

   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .operand  (opnd),
      .mode     (mode_r),
      .acc_next (acc_step),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      launch  = 1'b0;
      mt_wr   = 1'b0;
      commit  = 1'b0;
      unique case (state)
         S_IDLE: begin
            // a kill in the same cycle as an issue drops the issue entirely
            if (bus.start && !bus.flush) begin
               if (op_is_muldiv(bus.op)) begin
                  launch  = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                  state_n = op_is_div(bus.op) ? S_CALC : S_FIX;
`else
                  state_n = S_CALC;
`endif
               end
               mt_wr = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
            end
         end
         S_CALC: begin
            if (bus.flush)
               state_n = S_IDLE;
            else if (cnt == CNT_W'(1))
               state_n = S_FIX;
         end
         S_FIX: begin
            state_n = S_IDLE;
            commit  = !bus.flush;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         opnd   <= '0;
         cnt    <= '0;
         mode_r <= M_MUL;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= commit;

         if (launch) begin
            cnt    <= CNT_W'(WIDTH);
            mode_r <= op_is_div(bus.op) ? M_DIV : M_MUL;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= op_is_div(bus.op) && (bus.src_b == '0);
            if (op_is_div(bus.op)) begin
               // divide by zero runs on the raw dividend so the remainder comes out as src_a
               if (bus.src_b == '0) begin
                  acc  <= {{WIDTH{1'b0}}, bus.src_a};
                  opnd <= '0;
               end else begin
                  acc  <= {{WIDTH{1'b0}}, a_mag};
                  opnd <= b_mag;
               end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
               acc   <= fprod;
               neg_q <= 1'b0;
`else
               acc  <= {{WIDTH{1'b0}}, b_mag};
               opnd <= a_mag;
`endif
            end
         end

         if (state == S_CALC && !bus.flush) begin
            acc <= (mode_r == M_DIV) ? {acc_step[2*WIDTH-1:1], q_bit} : acc_step;
            cnt <= cnt - CNT_W'(1);
         end

         if (mt_wr) begin
            if (bus.op == OP_MTHI)
               hi_r <= bus.src_a;
            else
               lo_r <= bus.src_a;
         end

         if (commit) begin
            if (mode_r == M_MUL) begin
               hi_r <= prod_fix[2*WIDTH-1:WIDTH];
               lo_r <= prod_fix[WIDTH-1:0];
            end else if (div0) begin
               hi_r <= acc[2*WIDTH-1:WIDTH];
               lo_r <= DIV0_QUOT[WIDTH-1:0];
            end else begin
               hi_r <= rem_fix;
               lo_r <= quot_fix;
            end
         end
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - directed-vector self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int         MUL_LAT  = 2;
   localparam logic [2:0] FLUSH_OP = OP_DIVU;
`else
   localparam int         MUL_LAT  = 34;
   localparam logic [2:0] FLUSH_OP = OP_MULT;
`endif
   localparam int DIV_LAT = 34;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

   hilo_muldiv_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int lat, output int bviol);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
      @(posedge clk);
      lat   = 1;
      bviol = 0;
      @(negedge clk);
      bus.start = 1'b0; bus.src_a = '0; bus.src_b = '0;
      while (!bus.done && lat < 200) begin
         if (!bus.busy) bviol++;
         if (inject && lat == 10) begin
            bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat, bviol;
      run_op(o, a, b, inject, lat, bviol);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      check({tag, "_busy_gap"}, 64'(bviol), 64'd0);
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int done_seen;
      rst = 1'b1;
      bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);

      do_op("t1_mult", OP_MULT, 32'd7, 32'd6, 1'b0, MUL_LAT, 32'd0, 32'd42);
      do_op("t2_multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("t2_mult", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MUL_LAT, 32'h0, 32'h1);
      do_op("t2_mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      do_op("t3_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("t3_divu_inj", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b1, DIV_LAT, 32'h1, 32'h7FFF_FFFC);
      do_op("t4_divu0", OP_DIVU, 32'h1234, 32'd0, 1'b0, DIV_LAT, 32'h1234, 32'hFFFF_FFFF);
      do_op("t4_div0_min", OP_DIV, 32'h8000_0000, 32'd0, 1'b0, DIV_LAT, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("t4_div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_LAT, 32'h0, 32'h8000_0000);
      do_op("t4_div0_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // MTHI: immediate write, never busy, never done
      bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'hAAAA;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("t5_mthi_hi", 64'(bus.hi), 64'hAAAA);
      check("t5_mthi_busy", 64'(bus.busy), 64'd0);
      check("t5_mthi_done", 64'(bus.done), 64'd0);

      // start and flush together while idle: dropped
      bus.start = 1'b1; bus.op = OP_MTLO; bus.src_a = 32'h5555; bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t5_idle_flush_lo", 64'(bus.lo), 64'hFFFF_FFFF);
      bus.op = OP_MULT; bus.src_a = 32'd3; bus.src_b = 32'd5;
      @(posedge clk);
      @(negedge clk);
      check("t5_idle_flush_busy", 64'(bus.busy), 64'd0);
      bus.start = 1'b0; bus.flush = 1'b0;

      // flush of an in-flight op, with a second start ignored mid-flight
      bus.start = 1'b1; bus.op = FLUSH_OP; bus.src_a = 32'd3; bus.src_b = 32'd5;
      @(posedge clk);
      done_seen = 0;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
         bus.start = (c == 5);
         bus.op = OP_MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
         @(posedge clk);
      end
      @(negedge clk);
      check("t5_busy_before_flush", 64'(bus.busy), 64'd1);
      bus.start = 1'b0; bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      check("t5_flush_busy", 64'(bus.busy), 64'd0);
      for (int c = 0; c < 40; c++) begin
         if (bus.done) done_seen++;
         @(negedge clk);
      end
      check("t5_flush_no_done", 64'(done_seen), 64'd0);
      check("t5_flush_hi", 64'(bus.hi), 64'hAAAA);
      check("t5_flush_lo", 64'(bus.lo), 64'hFFFF_FFFF);

      // reset mid-divide
      bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("t6_rst_hi", 64'(bus.hi), 64'd0);
      check("t6_rst_lo", 64'(bus.lo), 64'd0);
      check("t6_rst_busy", 64'(bus.busy), 64'd0);
      check("t6_rst_done", 64'(bus.done), 64'd0);

      do_op("t6_after_rst", OP_DIV, 32'd100, 32'd7, 1'b0, DIV_LAT, 32'd2, 32'd14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
